// File: rtl/resonant_pkg.sv
// Shared types, constants and the saturating multiply used by the Q pulse
// deserializer and the resonant-system emulator.
package resonant_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      COUNTING = 2'd2,
      DONE     = 2'd3
   } deser_state_t;

   localparam int BUS_WIDTH_DEFAULT   = 10;
   localparam int Q_PER_PULSE_DEFAULT = 30;
   localparam int Q_MAX               = 2**BUS_WIDTH_DEFAULT - 1;

   typedef struct packed {
      logic [31:0] value;
      logic        clipped;
   } sat_res_t;

   // n * q clipped to max; the flag reports whether clipping occurred.
   function automatic sat_res_t sat_mul(input logic [31:0] n,
                                        input logic [31:0] q,
                                        input logic [31:0] max);
      logic [63:0] prod;
      sat_res_t    r;
      prod = 64'(n) * 64'(q);
      if (prod > 64'(max)) begin
         r.value   = max;
         r.clipped = 1'b1;
      end else begin
         r.value   = prod[31:0];
         r.clipped = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/q_pulse_deserializer_if.sv
// Result bus of the Q pulse deserializer: valid/ready handshake plus payload.
interface q_pulse_deserializer_if #(
   parameter int BUS_WIDTH = 10
);
   logic                 q_valid;
   logic                 q_ready;
   logic [BUS_WIDTH-1:0] q_measured;
   logic [BUS_WIDTH-1:0] n_pulses;
   logic                 q_sat;
   logic                 q_timeout;

   modport master (
      output q_valid, q_measured, n_pulses, q_sat, q_timeout,
      input  q_ready
   );

   modport slave (
      input  q_valid, q_measured, n_pulses, q_sat, q_timeout,
      output q_ready
   );
endinterface

// File: rtl/pulse_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level followed by a registered
// previous-value flop, giving rising-edge and any-edge strobes in the clk domain.
module pulse_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic any_edge
);
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;
   logic                   s_s;

   assign s_s = sync_r[SYNC_STAGES-1];

   // Synchronizer chain and previous-value flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= '0;
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], d};
         prev_r <= s_s;
      end
   end

   assign rise     = s_s & ~prev_r;
   assign any_edge = s_s ^ prev_r;
endmodule

// File: rtl/q_pulse_deserializer.sv
// Counts synchronized rising edges of the serialized Q pulse train, ends the
// train on an idle timeout and reports n_pulses and the clipped charge.
module q_pulse_deserializer
   import resonant_pkg::*;
#(
   parameter int BUS_WIDTH    = BUS_WIDTH_DEFAULT,
   parameter int Q_PER_PULSE  = Q_PER_PULSE_DEFAULT,
   parameter int IDLE_TIMEOUT = 16,
   parameter int ARM_TIMEOUT  = 256,
   parameter int SYNC_STAGES  = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic q_serialized,
   output logic busy,
   q_pulse_deserializer_if.master res
);
   localparam logic [1:0] ST_IDLE     = 2'(IDLE);
   localparam logic [1:0] ST_ARMED    = 2'(ARMED);
   localparam logic [1:0] ST_COUNTING = 2'(COUNTING);
   localparam logic [1:0] ST_DONE     = 2'(DONE);

   localparam int AW = (ARM_TIMEOUT  > 2) ? $clog2(ARM_TIMEOUT)  : 1;
   localparam int IW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [AW-1:0]        ARM_LAST  = AW'(ARM_TIMEOUT - 1);
   localparam logic [IW-1:0]        IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
   localparam logic [BUS_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [31:0]          RES_MAX   = 32'(2**BUS_WIDTH - 1);

   logic [1:0]           state_r, state_s;
   logic [BUS_WIDTH-1:0] count_r, count_s;
   logic [IW-1:0]        idle_r, idle_s;
   logic [AW-1:0]        arm_r, arm_s;
   logic [BUS_WIDTH-1:0] n_r, n_s, qm_r, qm_s;
   logic                 sat_r, sat_s, to_r, to_s, valid_r, valid_s, busy_r, busy_s;
   logic                 rise_s, any_edge_s;
   sat_res_t             prod_s;
   logic                 unused_prod_hi_s;

   pulse_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .d        (q_serialized),
      .rise     (rise_s),
      .any_edge (any_edge_s)
   );

   assign prod_s           = sat_mul(32'(count_r), 32'(Q_PER_PULSE), RES_MAX);
   assign unused_prod_hi_s = ^prod_s.value[31:BUS_WIDTH];

   // Next-state and result computation; abort is tested before any other event.
   always_comb begin
      state_s = state_r;
      count_s = count_r;
      idle_s  = idle_r;
      arm_s   = arm_r;
      n_s     = n_r;
      qm_s    = qm_r;
      sat_s   = sat_r;
      to_s    = to_r;
      valid_s = valid_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               count_s = '0;
               idle_s  = '0;
               arm_s   = '0;
               sat_s   = 1'b0;
               to_s    = 1'b0;
               state_s = ST_ARMED;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (!start) begin
               state_s = ST_IDLE;
            end else if (rise_s) begin
               count_s = {{(BUS_WIDTH-1){1'b0}}, 1'b1};
               idle_s  = '0;
               state_s = ST_COUNTING;
            end else if (arm_r == ARM_LAST) begin
               count_s = '0;
               to_s    = 1'b1;
               state_s = ST_DONE;
            end else begin
               arm_s = arm_r + 1'b1;
            end
         end
         ST_COUNTING: begin
            // A rise also sets any_edge, so it always clears the idle counter.
            if (!start) begin
               state_s = ST_IDLE;
            end else if (any_edge_s) begin
               idle_s = '0;
               if (rise_s && (count_r == CNT_MAX)) begin
                  sat_s = 1'b1;
               end else if (rise_s) begin
                  count_s = count_r + 1'b1;
               end else begin
                  count_s = count_r;
               end
            end else if (idle_r == IDLE_LAST) begin
               state_s = ST_DONE;
            end else begin
               idle_s = idle_r + 1'b1;
            end
         end
         ST_DONE: begin
            if (!valid_r) begin
               n_s     = count_r;
               qm_s    = prod_s.value[BUS_WIDTH-1:0];
               sat_s   = sat_r | prod_s.clipped;
               valid_s = 1'b1;
            end else if (res.q_ready) begin
               valid_s = 1'b0;
               state_s = ST_IDLE;
            end else begin
               valid_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         count_r <= '0;
         idle_r  <= '0;
         arm_r   <= '0;
         n_r     <= '0;
         qm_r    <= '0;
         sat_r   <= 1'b0;
         to_r    <= 1'b0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         count_r <= count_s;
         idle_r  <= idle_s;
         arm_r   <= arm_s;
         n_r     <= n_s;
         qm_r    <= qm_s;
         sat_r   <= sat_s;
         to_r    <= to_s;
         valid_r <= valid_s;
         busy_r  <= busy_s;
      end
   end

   assign res.q_valid    = valid_r;
   assign res.q_measured = qm_r;
   assign res.n_pulses   = n_r;
   assign res.q_sat      = sat_r;
   assign res.q_timeout  = to_r;
   assign busy           = busy_r;
endmodule

// File: tb/tb_q_pulse_deserializer.sv
// Directed bench for q_pulse_deserializer: a table of pulse trains with
// hand-computed results, then abort, backpressure and reset sequences.
module tb_q_pulse_deserializer;
   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic q_serialized;
   logic busy;

   q_pulse_deserializer_if #(.BUS_WIDTH(10)) bus ();

   q_pulse_deserializer #(
      .BUS_WIDTH    (10),
      .Q_PER_PULSE  (30),
      .IDLE_TIMEOUT (16),
      .ARM_TIMEOUT  (256),
      .SYNC_STAGES  (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .q_serialized (q_serialized),
      .busy         (busy),
      .res          (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   pulses;
      int   exp_n;
      int   exp_q;
      logic exp_sat;
      logic exp_to;
      int   lat_lo;
      int   lat_hi;
   } vec_t;

   vec_t vecs[6];
   int   checks = 0;
   int   errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic send_pulses(input int n);
      for (int p = 0; p < n; p++) begin
         q_serialized = 1'b1;
         repeat (4) tick();
         q_serialized = 1'b0;
         repeat (4) tick();
      end
   endtask

   task automatic wait_valid(input int limit, output int cyc);
      cyc = -1;
      for (int c = 1; c <= limit; c++) begin
         tick();
         if (bus.q_valid) begin
            cyc = c;
            break;
         end
      end
   endtask

   int  cyc;
   int  seen;
   int  last_n;
   int  last_q;

   initial begin
      // pulses, n, q, sat, timeout, latency window (from last fall, or from start)
      vecs[0] = '{5,  5,  150,  1'b0, 1'b0, 19,  21};
      vecs[1] = '{40, 40, 1023, 1'b1, 1'b0, 19,  21};
      vecs[2] = '{0,  0,  0,    1'b0, 1'b1, 257, 259};
      vecs[3] = '{1,  1,  30,   1'b0, 1'b0, 19,  21};
      vecs[4] = '{34, 34, 1020, 1'b0, 1'b0, 19,  21};
      vecs[5] = '{35, 35, 1023, 1'b1, 1'b0, 19,  21};

      rst_n        = 1'b0;
      start        = 1'b0;
      q_serialized = 1'b0;
      bus.q_ready  = 1'b0;
      repeat (3) tick();
      chk("rst_valid",   int'(bus.q_valid),    0);
      chk("rst_q",       int'(bus.q_measured), 0);
      chk("rst_n_pulses",int'(bus.n_pulses),   0);
      chk("rst_sat",     int'(bus.q_sat),      0);
      chk("rst_timeout", int'(bus.q_timeout),  0);
      chk("rst_busy",    int'(busy),           0);
      rst_n = 1'b1;
      tick();

      last_n = 0;
      last_q = 0;
      for (int i = 0; i < 6; i++) begin
         start       = 1'b1;
         bus.q_ready = 1'b1;
         send_pulses(vecs[i].pulses);
         wait_valid(400, cyc);
         chk($sformatf("v%0d_valid_seen", i), int'(cyc >= 0), 1);
         chk_range($sformatf("v%0d_latency", i),
                   (vecs[i].pulses > 0) ? cyc + 4 : cyc, vecs[i].lat_lo, vecs[i].lat_hi);
         chk($sformatf("v%0d_n_pulses", i), int'(bus.n_pulses),   vecs[i].exp_n);
         chk($sformatf("v%0d_q", i),        int'(bus.q_measured), vecs[i].exp_q);
         chk($sformatf("v%0d_sat", i),      int'(bus.q_sat),      int'(vecs[i].exp_sat));
         chk($sformatf("v%0d_timeout", i),  int'(bus.q_timeout),  int'(vecs[i].exp_to));
         chk($sformatf("v%0d_busy_done", i),int'(busy),           1);
         tick();
         chk($sformatf("v%0d_valid_one_cycle", i), int'(bus.q_valid), 0);
         chk($sformatf("v%0d_idle_after_accept", i), int'(busy), 0);
         tick();
         chk($sformatf("v%0d_rearm", i), int'(busy), 1);
         start = 1'b0;
         repeat (2) tick();
         chk($sformatf("v%0d_abort_idle", i), int'(busy), 0);
         last_n = vecs[i].exp_n;
         last_q = vecs[i].exp_q;
      end

      // Abort after two pulses: no result, previous payload untouched.
      start = 1'b1;
      send_pulses(2);
      chk("abort_busy_before", int'(busy), 1);
      start = 1'b0;
      tick();
      chk("abort_busy", int'(busy), 0);
      chk("abort_keep_n", int'(bus.n_pulses),   last_n);
      chk("abort_keep_q", int'(bus.q_measured), last_q);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.q_valid) seen = 1;
      end
      chk("abort_no_valid", seen, 0);

      // Backpressure: result held stable while q_ready is low.
      start       = 1'b1;
      bus.q_ready = 1'b0;
      send_pulses(3);
      wait_valid(100, cyc);
      chk("bp_valid_seen", int'(cyc >= 0), 1);
      chk("bp_q", int'(bus.q_measured), 90);
      chk("bp_n", int'(bus.n_pulses),   3);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("bp_hold_valid_%0d", c), int'(bus.q_valid),    1);
         chk($sformatf("bp_hold_q_%0d", c),     int'(bus.q_measured), 90);
      end
      bus.q_ready = 1'b1;
      start       = 1'b0;
      tick();
      chk("bp_accept_valid", int'(bus.q_valid), 0);
      chk("bp_accept_busy",  int'(busy),        0);
      tick();
      chk("bp_stay_idle", int'(busy), 0);

      // Asynchronous reset in the middle of a train.
      start = 1'b1;
      send_pulses(2);
      chk("rstmid_busy_before", int'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_q",     int'(bus.q_measured), 0);
      chk("rstmid_n",     int'(bus.n_pulses),   0);
      chk("rstmid_busy",  int'(busy),           0);
      chk("rstmid_valid", int'(bus.q_valid),    0);
      tick();
      rst_n = 1'b1;
      send_pulses(1);
      wait_valid(100, cyc);
      chk("rstmid_valid_seen", int'(cyc >= 0), 1);
      chk("rstmid_fresh_n", int'(bus.n_pulses),   1);
      chk("rstmid_fresh_q", int'(bus.q_measured), 30);
      chk("rstmid_fresh_sat", int'(bus.q_sat),    0);
      start = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
